// File: rtl/data_memory_resp.sv
// -----------------------------------------------------------------------------
// data_memory_resp
//   Responder end of the core's mem_* data bus. Serves a byte-lane RAM with a
//   one-cycle registered read, plus a four-word MMIO window:
//     word 0 TX   : lane-0 write pushes mem_d[7:0] into the byte log FIFO
//     word 1 STAT : {24'b0, cnt[3:0], 1'b0, ovf, full, empty}; writing with
//                   mem_d[2]=1 on lane 0 clears the sticky overflow flag
//     word 2 CYC  : free-running 32-bit cycle counter (read-only)
//     word 3      : reads 0, writes ignored
//   mem_addr[ADDR_W] selects MMIO (1) or RAM (0); higher address bits alias.
//
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high
//   mem_ce     per-byte-lane chip enable (lane i = bits 8i+7:8i)
//   mem_we     per-lane write enable, qualified by mem_ce
//   mem_addr   word address
//   mem_d      write data
//   mem_q      registered read data; unread lanes hold their previous value
//   log_valid  log FIFO head valid
//   log_data   log FIFO head byte (0 when empty)
//   log_ready  reader accepts the head when log_valid & log_ready
//
// Configuration
//   DMEM_WR_FWD_EN  when defined, RAM lanes written this cycle are also loaded
//                   into mem_q (write-through). Undefined: written lanes hold.
// -----------------------------------------------------------------------------
module data_memory_resp #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_ce,
  input  logic [3:0]  mem_we,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_d,
  output logic [31:0] mem_q,
  output logic        log_valid,
  output logic [7:0]  log_data,
  input  logic        log_ready
);

  localparam int RAM_WORDS = 2 ** ADDR_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    MMIO_TX   = 2'd0,
    MMIO_STAT = 2'd1,
    MMIO_CYC  = 2'd2,
    MMIO_RSVD = 2'd3
  } mmio_reg_e;

  // Address decode
  logic             is_mmio;
  logic [ADDR_W-1:0] ram_idx;
  mmio_reg_e        mmio_sel;
  logic             unused_addr_bits;

  assign is_mmio          = mem_addr[ADDR_W];
  assign ram_idx          = mem_addr[ADDR_W-1:0];
  assign mmio_sel         = mmio_reg_e'(mem_addr[1:0]);
  assign unused_addr_bits = ^mem_addr[29:ADDR_W+1];

  // Per-lane strobes. An access sampled while reset is high is discarded.
  logic [3:0] lane_wr;
  logic [3:0] lane_rd;
  logic [3:0] ram_we;

  assign lane_wr = mem_ce & mem_we;
  assign lane_rd = mem_ce & ~mem_we;
  assign ram_we  = lane_wr & {4{~is_mmio & ~reset}};

  // RAM storage
  logic [3:0][7:0] ram [RAM_WORDS];

  // NOTE: storage arrays have no reset branch; clearing them would turn the
  // RAM into thousands of flops. Contents are undefined until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) ram[ram_idx][i] <= mem_d[8*i +: 8];
    end
  end

  // Log FIFO and MMIO state
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [31:0]      cyc;

  logic fifo_empty;
  logic fifo_full;
  logic tx_push;
  logic pop;
  logic push_ok;
  logic ovf_set;
  logic ovf_clr;

  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == CNT_W'(FIFO_DEPTH));
  assign tx_push    = is_mmio && (mmio_sel == MMIO_TX) && lane_wr[0];
  assign pop        = log_valid && log_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = tx_push && (!fifo_full || pop);
  assign ovf_set    = tx_push && fifo_full && !pop;
  assign ovf_clr    = is_mmio && (mmio_sel == MMIO_STAT) && lane_wr[0] && mem_d[2];

  always_ff @(posedge clk) begin
    if (push_ok && !reset) fifo_mem[wr_ptr] <= mem_d[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      cyc    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop);
      // Set has priority over a same-cycle clear.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      cyc <= cyc + 32'd1;
    end
  end

  assign log_valid = !fifo_empty;
  assign log_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // Read data mux
  logic [31:0] stat_word;
  logic [31:0] rd_word;

  assign stat_word = {24'b0, 4'(cnt), 1'b0, ovf, fifo_full, fifo_empty};

  // NOTE: rd_word gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    if (is_mmio) begin
      case (mmio_sel)
        MMIO_STAT: rd_word = stat_word;
        MMIO_CYC:  rd_word = cyc;
        default:   rd_word = '0;
      endcase
    end else begin
      rd_word = ram[ram_idx];
    end
  end

  // Registered read, per-lane hold
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_rd[i]) begin
          mem_q[8*i +: 8] <= rd_word[8*i +: 8];
        end
`ifdef DMEM_WR_FWD_EN
        else if (ram_we[i]) begin
          mem_q[8*i +: 8] <= mem_d[8*i +: 8];
        end
`else
        else begin
          mem_q[8*i +: 8] <= mem_q[8*i +: 8];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_data_memory_resp.sv
// -----------------------------------------------------------------------------
// tb_data_memory_resp
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (word array, byte queue, overflow flag, cycle count) predicts mem_q,
//   log_valid and log_data after every clock edge.
// -----------------------------------------------------------------------------
module tb_data_memory_resp;

  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RAM_WORDS  = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mem_ce = '0;
  logic [3:0]  mem_we = '0;
  logic [29:0] mem_addr = '0;
  logic [31:0] mem_d = '0;
  logic [31:0] mem_q;
  logic        log_valid;
  logic [7:0]  log_data;
  logic        log_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_memory_resp #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_d     (mem_d),
    .mem_q     (mem_q),
    .log_valid (log_valid),
    .log_data  (log_data),
    .log_ready (log_ready)
  );

  // Reference model state
  logic [31:0] ram_m [RAM_WORDS];
  logic [31:0] q_m = '0;
  logic [7:0]  fifo_q [$];
  bit          ovf_m = 1'b0;
  logic [31:0] cyc_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Address with random alias bits above the decode field.
  function automatic logic [29:0] mk_addr(input bit mmio, input int idx);
    logic [29:0] a;
    a = 30'($urandom);
    a[ADDR_W] = mmio;
    if (mmio) a[1:0] = 2'(idx);
    else      a[ADDR_W-1:0] = ADDR_W'(idx);
    return a;
  endfunction

  function automatic logic [31:0] stat_m();
    int n;
    n = fifo_q.size();
    return {24'b0, 4'(n), 1'b0, ovf_m, (n == FIFO_DEPTH), (n == 0)};
  endfunction

  // Drive one access, advance the model across the edge, compare after it.
  task automatic step(input logic [3:0] ce, input logic [3:0] we,
                      input logic [29:0] addr, input logic [31:0] d);
    logic [31:0] rd;
    bit mmio, pop, push, set_f, clr_f;
    int off, idx;
    mem_ce = ce; mem_we = we; mem_addr = addr; mem_d = d;
    mmio = addr[ADDR_W];
    off  = int'(addr[1:0]);
    idx  = int'(addr[ADDR_W-1:0]);
    if (reset) begin
      q_m = '0;
      fifo_q.delete();
      ovf_m = 1'b0;
      cyc_m = '0;
    end else begin
      if (mmio) begin
        case (off)
          1:       rd = stat_m();
          2:       rd = cyc_m;
          default: rd = '0;
        endcase
      end else begin
        rd = ram_m[idx];
      end
      for (int i = 0; i < 4; i++) begin
        if (ce[i] && !we[i]) q_m[8*i +: 8] = rd[8*i +: 8];
`ifdef DMEM_WR_FWD_EN
        else if (ce[i] && we[i] && !mmio) q_m[8*i +: 8] = d[8*i +: 8];
`endif
      end
      if (!mmio) begin
        for (int i = 0; i < 4; i++)
          if (ce[i] && we[i]) ram_m[idx][8*i +: 8] = d[8*i +: 8];
      end
      pop   = (fifo_q.size() > 0) && log_ready;
      push  = mmio && (off == 0) && ce[0] && we[0];
      clr_f = mmio && (off == 1) && ce[0] && we[0] && d[2];
      set_f = 1'b0;
      if (pop) void'(fifo_q.pop_front());
      if (push) begin
        if (fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(d[7:0]);
        else set_f = 1'b1;
      end
      if (set_f)      ovf_m = 1'b1;
      else if (clr_f) ovf_m = 1'b0;
      cyc_m = cyc_m + 32'd1;
    end
    @(posedge clk);
    #1;
    check("mem_q", mem_q, q_m);
    check("log_valid", 32'(log_valid), 32'(fifo_q.size() > 0));
    check("log_data", 32'(log_data), (fifo_q.size() > 0) ? 32'(fifo_q[0]) : 32'h0);
  endtask

  task automatic idle();
    step(4'h0, 4'h0, mk_addr(1'b0, 0), 32'($urandom));
  endtask

  logic [31:0] v1, v2;
  logic [7:0]  exp_bytes [4];

  initial begin
    // 1: reset, then STAT reads empty
    reset = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    check("reset_mem_q", mem_q, 32'h0);
    check("reset_log_valid", 32'(log_valid), 32'h0);
    reset = 1'b0;
    step(4'hF, 4'h0, mk_addr(1'b1, 1), 32'h0);
    check("stat_after_reset", mem_q, 32'h0000_0001);

    // 2: full-word write/read, then lane-2 partial write
    step(4'hF, 4'hF, mk_addr(1'b0, 4), 32'hDEAD_BEEF);
    step(4'hF, 4'h0, mk_addr(1'b0, 4), 32'h0);
    check("ram_read_full", mem_q, 32'hDEAD_BEEF);
    step(4'b0100, 4'b0100, mk_addr(1'b0, 4), 32'h0011_0000);
    step(4'hF, 4'h0, mk_addr(1'b0, 4), 32'h0);
    check("ram_read_lane2", mem_q, 32'hDE11_BEEF);

    // 3: partial read holds upper lanes
    step(4'hF, 4'hF, mk_addr(1'b0, 5), 32'hAAAA_AAAA);
    step(4'hF, 4'h0, mk_addr(1'b0, 5), 32'h0);
    check("ram_read_aaaa", mem_q, 32'hAAAA_AAAA);
    step(4'b0011, 4'h0, mk_addr(1'b0, 4), 32'h0);
    check("partial_read_hold", mem_q, 32'hAAAA_BEEF);

    // 4: overflow, in-order drain, ovf clear
    log_ready = 1'b0;
    for (int k = 0; k < 5; k++) step(4'b0001, 4'b0001, mk_addr(1'b1, 0), 32'h41 + 32'(k));
    step(4'hF, 4'h0, mk_addr(1'b1, 1), 32'h0);
    check("stat_full_ovf", mem_q, 32'h0000_0046);
    log_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_order", 32'(log_data), 32'h41 + 32'(k));
      idle();
    end
    check("drained_empty", 32'(log_valid), 32'h0);
    log_ready = 1'b0;
    step(4'b0001, 4'b0001, mk_addr(1'b1, 1), 32'h4);
    step(4'hF, 4'h0, mk_addr(1'b1, 1), 32'h0);
    check("stat_ovf_cleared", mem_q, 32'h0000_0001);

    // 5: push into a full FIFO while the head pops
    for (int k = 0; k < 4; k++) step(4'b0001, 4'b0001, mk_addr(1'b1, 0), 32'h31 + 32'(k));
    log_ready = 1'b1;
    step(4'b0001, 4'b0001, mk_addr(1'b1, 0), 32'h5A);
    log_ready = 1'b0;
    step(4'hF, 4'h0, mk_addr(1'b1, 1), 32'h0);
    check("stat_full_no_ovf", mem_q, 32'h0000_0042);
    exp_bytes[0] = 8'h32; exp_bytes[1] = 8'h33; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h5A;
    log_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_push_pop", 32'(log_data), 32'(exp_bytes[k]));
      idle();
    end
    log_ready = 1'b0;

    // 6: cycle counter delta, write-through behaviour
    step(4'hF, 4'h0, mk_addr(1'b1, 2), 32'h0);
    v1 = mem_q;
    for (int k = 0; k < 9; k++) idle();
    step(4'hF, 4'h0, mk_addr(1'b1, 2), 32'h0);
    v2 = mem_q;
    check("cyc_delta", v2 - v1, 32'd10);
    step(4'hF, 4'hF, mk_addr(1'b0, 7), 32'h1234_5678);
`ifdef DMEM_WR_FWD_EN
    check("write_through", mem_q, 32'h1234_5678);
`else
    check("write_hold", mem_q, v2);
`endif
    step(4'hF, 4'h0, mk_addr(1'b1, 3), 32'h0);
    check("mmio_rsvd_zero", mem_q, 32'h0);

    // Reset mid-stream discards FIFO and the access sampled with it
    for (int k = 0; k < 2; k++) step(4'b0001, 4'b0001, mk_addr(1'b1, 0), 32'h50 + 32'(k));
    reset = 1'b1;
    step(4'hF, 4'hF, mk_addr(1'b0, 4), 32'h0BAD_0BAD);
    reset = 1'b0;
    check("midreset_log_valid", 32'(log_valid), 32'h0);
    check("midreset_mem_q", mem_q, 32'h0);
    step(4'hF, 4'h0, mk_addr(1'b0, 4), 32'h0);
    check("ram_survives_reset", mem_q, 32'hDE11_BEEF);

    // Randomized traffic: initialise every RAM word, then mixed accesses
    for (int w = 0; w < RAM_WORDS; w++) step(4'hF, 4'hF, mk_addr(1'b0, w), $urandom);
    for (int n = 0; n < 2000; n++) begin
      bit mmio;
      log_ready = 1'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      mmio = ($urandom_range(0, 3) == 0);
      step(4'($urandom), 4'($urandom),
           mk_addr(mmio, mmio ? $urandom_range(0, 3) : $urandom_range(0, RAM_WORDS - 1)),
           $urandom);
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
